phase_freq_detector: RTL and testbench
======================================

// Module: phase_freq_detector
// PURPOSE
//  ADPLL front end. Samples asynchronous ref_clk_i and fb_clk_i (DCO feedback) on fpga_clk_i.
//  Turns the rising-edge phase difference into COUNT_UP/COUNT_DOWN/DISABLE instructions.
//  Directly drives UpDownCounter count_instr_i / clear_i; the counter accumulates the phase error.
//  Also reports window completion, cycle slips, timeouts and a lock indication.
// PARAMETERS
//  SYNC_STAGES        2     synchroniser flops per async input (>=2)
//  MAX_WINDOW         4096  max window length in fpga_clk cycles before forced close (timeout)
//  LOCK_TOL           4     window length (cycles) at or below which a window is "in tolerance"
//  LOCK_COUNT         16    consecutive in-tolerance windows needed to assert lock_o
//  CLEAR_EACH_WINDOW  1     1: clear_o pulses with done_o; 0: clear_o held low
// PORTS
//  fpga_clk_i     in   1   system clock
//  reset_i        in   1   reset; asynchronous, active-high
//  ref_clk_i      in   1   reference clock, async to fpga_clk_i
//  fb_clk_i       in   1   divided DCO feedback, async to fpga_clk_i
//  count_instr_o  out  2   to UpDownCounter: 00 DISABLE, 01 COUNT_UP, 10 COUNT_DOWN
//  clear_o        out  1   to UpDownCounter clear_i
//  done_o         out  1   1-cycle pulse: window closed, counter value final this cycle
//  slip_o         out  1   1-cycle pulse: cycle slip detected
//  timeout_o      out  1   1-cycle pulse: window forced closed at MAX_WINDOW
//  lock_o         out  1   loop locked
// BEHAVIOUR
//  Reset (async, all flops): sync chains 0, state IDLE, count_instr_o=DISABLE, all pulses 0, lock_o=0, counters 0.
//  Front end: each input passes SYNC_STAGES flops plus one history flop.
//   rise = sync & ~hist. Edge-to-rise latency is SYNC_STAGES+1 cycles, identical for both inputs.
//  FSM states IDLE, REF_LEAD, FB_LEAD. All outputs are registered and update on the transition edge.
//   IDLE: ref_rise&fb_rise -> stay IDLE; zero-length window: done_o=1, count_instr stays DISABLE.
//         ref_rise only -> REF_LEAD, count_instr_o<=COUNT_UP. fb_rise only -> FB_LEAD, <=COUNT_DOWN.
//   REF_LEAD: fb_rise -> IDLE, count_instr_o<=DISABLE, done_o<=1.
//         ref_rise without fb_rise -> slip_o<=1, stay REF_LEAD, keep counting.
//         ref_rise coincident with fb_rise -> close as normal, slip_o<=1, ref edge discarded.
//   FB_LEAD: mirror of REF_LEAD with ref/fb and UP/DOWN swapped.
//  Window counter: cleared on entry to a LEAD state; increments each cycle in a LEAD state; saturates.
//   Window length = number of cycles count_instr_o was non-DISABLE.
//   Reaching MAX_WINDOW -> IDLE, DISABLE, done_o=1, timeout_o=1.
//  Timing vs counter: counter takes its last step on the edge that closes the window, so
//   counter_val is final while done_o=1. clear_o = done_o & CLEAR_EACH_WINDOW, so the
//   counter clears on the next edge, at which the consumer samples the old value.
//   A new window opened from IDLE issues its first step no earlier than that clear edge+1,
//   so no step is lost.
//  Lock: on each done_o, win_len<=LOCK_TOL and no slip/timeout -> good_cnt++ (saturate at LOCK_COUNT).
//   Otherwise good_cnt<=0 and lock_o<=0. lock_o<=1 when good_cnt reaches LOCK_COUNT.
//   A slip_o outside a window close also clears good_cnt and lock_o.
//  count_instr_o never takes 11. Reset mid-window forces IDLE/DISABLE immediately (async).
// STRUCTURE
//  Shared header adpll_defs.vh: DISABLE/COUNT_UP/COUNT_DOWN encodings (shared with UpDownCounter),
//   FSM state encodings.
//  Sub-module edge_sync (SYNC_STAGES param): sync chain + rise detector, instanced for ref and fb.
//  Window counter width = $clog2(MAX_WINDOW+1). good_cnt width = $clog2(LOCK_COUNT+1).
// TESTING
//  1 Reset asserted mid REF_LEAD -> count_instr_o=00, lock_o=0 same cycle, no done_o after release.
//  2 ref leads fb by 10 fpga_clk cycles -> 10 cycles of 01, then done_o=clear_o=1.
//    UpDownCounter in loop reads +10 at done_o, 0 after.
//  3 fb leads ref by 7 cycles -> 7 cycles of 10; counter reads -7 at done_o.
//  4 ref/fb edges coincident -> done_o pulses, count_instr_o stays 00, counter stays 0.
//    16 such windows -> lock_o=1.
//  5 Two ref edges, no fb edge -> slip_o pulse on the 2nd edge; lock_o drops.
//    With MAX_WINDOW=64 and fb stopped -> timeout_o+done_o after 64 UP cycles.
//  6 Locked loop, one window of length LOCK_TOL+1=5 -> lock_o=0 on that done_o; relocks after 16 good windows.

Source files
------------

// File: rtl/phase_freq_detector_pkg.sv
// Shared encodings and sizing helpers for the ADPLL phase/frequency detector.
package phase_freq_detector_pkg;

    // Instruction encoding seen by the UpDownCounter
    typedef enum logic [1:0] {
        INSTR_DISABLE    = 2'b00,
        INSTR_COUNT_UP   = 2'b01,
        INSTR_COUNT_DOWN = 2'b10
    } count_instr_t;

    // Detector FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REF_LEAD = 2'b01,
        ST_FB_LEAD  = 2'b10
    } pfd_state_t;

    localparam int unsigned DEF_SYNC_STAGES       = 2;
    localparam int unsigned DEF_MAX_WINDOW        = 4096;
    localparam int unsigned DEF_LOCK_TOL          = 4;
    localparam int unsigned DEF_LOCK_COUNT        = 16;
    localparam int unsigned DEF_CLEAR_EACH_WINDOW = 1;

    // Bits needed to hold 0..max_val, never less than one
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phase_freq_detector_edge_sync.sv
// Synchroniser chain plus history flop; flags a rising edge of an async input.
module phase_freq_detector_edge_sync
    import phase_freq_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    // Shift the async level through the chain and remember the last synced value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/phase_freq_detector.sv
// ADPLL front end: converts ref/fb rising-edge phase difference into counter instructions.
module phase_freq_detector
    import phase_freq_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int unsigned MAX_WINDOW        = DEF_MAX_WINDOW,
    parameter int unsigned LOCK_TOL          = DEF_LOCK_TOL,
    parameter int unsigned LOCK_COUNT        = DEF_LOCK_COUNT,
    parameter int unsigned CLEAR_EACH_WINDOW = DEF_CLEAR_EACH_WINDOW
) (
    input  logic       fpga_clk_i,
    input  logic       reset_i,
    input  logic       ref_clk_i,
    input  logic       fb_clk_i,
    output logic [1:0] count_instr_o,
    output logic       clear_o,
    output logic       done_o,
    output logic       slip_o,
    output logic       timeout_o,
    output logic       lock_o
);

    localparam int unsigned WIN_W  = cnt_width(MAX_WINDOW);
    localparam int unsigned GOOD_W = cnt_width(LOCK_COUNT);

    localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(MAX_WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(MAX_WINDOW - 1);
    localparam logic [WIN_W-1:0]  WIN_TOL  = WIN_W'(LOCK_TOL);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);
    localparam logic              CLR_EN   = (CLEAR_EACH_WINDOW != 0);

    pfd_state_t        state;
    logic [WIN_W-1:0]  win_cnt;
    logic [GOOD_W-1:0] good_cnt;

    logic              ref_rise_c;
    logic              fb_rise_c;
    logic              lead_rise_c;
    logic              lag_rise_c;
    logic              in_lead_c;
    logic              close_edge_c;
    logic              timeout_c;
    logic              slip_c;
    logic              zero_win_c;
    logic              done_c;
    logic [WIN_W-1:0]  win_len_c;
    logic              good_win_c;
    logic [GOOD_W-1:0] good_inc_c;

    phase_freq_detector_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk      (fpga_clk_i),
        .rst      (reset_i),
        .async_in (ref_clk_i),
        .rise_c   (ref_rise_c)
    );

    phase_freq_detector_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk      (fpga_clk_i),
        .rst      (reset_i),
        .async_in (fb_clk_i),
        .rise_c   (fb_rise_c)
    );

    // Decode window events: which edge leads, closes, slips or times out this cycle
    always_comb begin
        lead_rise_c = 1'b0;
        lag_rise_c  = 1'b0;
        case (state)
            ST_REF_LEAD: begin
                lead_rise_c = ref_rise_c;
                lag_rise_c  = fb_rise_c;
            end
            ST_FB_LEAD: begin
                lead_rise_c = fb_rise_c;
                lag_rise_c  = ref_rise_c;
            end
            default: begin
                lead_rise_c = 1'b0;
                lag_rise_c  = 1'b0;
            end
        endcase

        in_lead_c    = (state != ST_IDLE);
        close_edge_c = in_lead_c & lag_rise_c;
        // A real closing edge wins over a timeout landing on the same cycle
        timeout_c    = in_lead_c & ~lag_rise_c & (win_cnt == WIN_LAST);
        slip_c       = in_lead_c & lead_rise_c;
        zero_win_c   = (state == ST_IDLE) & ref_rise_c & fb_rise_c;
        done_c       = close_edge_c | timeout_c | zero_win_c;
        // The closing cycle itself is the last counting cycle of the window
        win_len_c    = zero_win_c ? '0 : (win_cnt + WIN_W'(1));
        good_win_c   = (win_len_c <= WIN_TOL) & ~slip_c & ~timeout_c;
        good_inc_c   = (good_cnt == GOOD_MAX) ? good_cnt : (good_cnt + GOOD_W'(1));
    end

    // Detector FSM, window counter, lock tracking and registered outputs
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            count_instr_o <= INSTR_DISABLE;
            win_cnt       <= '0;
            good_cnt      <= '0;
            clear_o       <= 1'b0;
            done_o        <= 1'b0;
            slip_o        <= 1'b0;
            timeout_o     <= 1'b0;
            lock_o        <= 1'b0;
        end else begin
            done_o    <= done_c;
            clear_o   <= done_c & CLR_EN;
            slip_o    <= slip_c;
            timeout_o <= timeout_c;

            case (state)
                ST_IDLE: begin
                    win_cnt <= '0;
                    if (ref_rise_c && !fb_rise_c) begin
                        state         <= ST_REF_LEAD;
                        count_instr_o <= INSTR_COUNT_UP;
                    end else if (fb_rise_c && !ref_rise_c) begin
                        state         <= ST_FB_LEAD;
                        count_instr_o <= INSTR_COUNT_DOWN;
                    end
                end
                ST_REF_LEAD, ST_FB_LEAD: begin
                    if (close_edge_c || timeout_c) begin
                        state         <= ST_IDLE;
                        count_instr_o <= INSTR_DISABLE;
                        win_cnt       <= '0;
                    end else if (win_cnt != WIN_MAX) begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    count_instr_o <= INSTR_DISABLE;
                    win_cnt       <= '0;
                end
            endcase

            if (done_c) begin
                if (good_win_c) begin
                    good_cnt <= good_inc_c;
                    lock_o   <= (good_inc_c == GOOD_MAX);
                end else begin
                    good_cnt <= '0;
                    lock_o   <= 1'b0;
                end
            end else if (slip_c) begin
                good_cnt <= '0;
                lock_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phase_freq_detector.sv
// Directed, table-driven bench for phase_freq_detector with an UpDownCounter model in the loop.
module tb_phase_freq_detector;

    localparam int MAX_WIN = 64;
    localparam int PULSE   = 3;
    localparam int BUDGET  = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       ref_clk;
    logic       fb_clk;
    logic [1:0] count_instr;
    logic       clear;
    logic       done;
    logic       slip;
    logic       timeout;
    logic       lock;

    int n_tests = 0;
    int n_fail  = 0;
    int ctr;

    typedef struct {
        int ref_at;
        int ref2_at;
        int fb_at;
        int ups;
        int downs;
        int ctr;
        int slips;
        int timeouts;
        int lock;
    } vec_t;

    typedef struct {
        int ups;
        int downs;
        int illegal;
        int dones;
        int slips;
        int timeouts;
        int ctr_done;
        int clear_done;
        int lock_done;
        int ctr_after;
        int lock_slip;
    } res_t;

    vec_t vecs[$];

    phase_freq_detector #(
        .SYNC_STAGES       (2),
        .MAX_WINDOW        (MAX_WIN),
        .LOCK_TOL          (4),
        .LOCK_COUNT        (16),
        .CLEAR_EACH_WINDOW (1)
    ) dut (
        .fpga_clk_i    (clk),
        .reset_i       (rst),
        .ref_clk_i     (ref_clk),
        .fb_clk_i      (fb_clk),
        .count_instr_o (count_instr),
        .clear_o       (clear),
        .done_o        (done),
        .slip_o        (slip),
        .timeout_o     (timeout),
        .lock_o        (lock)
    );

    always #5 clk = ~clk;

    // UpDownCounter model consuming the detector outputs
    always @(posedge clk or posedge rst) begin
        if (rst)                     ctr <= 0;
        else if (clear)              ctr <= 0;
        else if (count_instr == 2'b01) ctr <= ctr + 1;
        else if (count_instr == 2'b10) ctr <= ctr - 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pulse_at(input int c, input int at);
        return (at >= 0) && (c >= at) && (c < at + PULSE);
    endfunction

    function automatic vec_t mk(input int ra, input int ra2, input int fa, input int u, input int d,
                                input int cv, input int s, input int t, input int l);
        vec_t v;
        v.ref_at = ra; v.ref2_at = ra2; v.fb_at = fa;
        v.ups = u; v.downs = d; v.ctr = cv; v.slips = s; v.timeouts = t; v.lock = l;
        return v;
    endfunction

    // Drive one window's pulses and observe outputs until one cycle past done_o
    task automatic run_window(input int ref_at, input int ref2_at, input int fb_at, output res_t r);
        int  c;
        int  last_end;
        bit  prev_done;
        bit  after_seen;
        bit  fin;
        r = '{default: 0};
        c = 0; prev_done = 1'b0; after_seen = 1'b0; fin = 1'b0;
        last_end = ref_at;
        if (ref2_at > last_end) last_end = ref2_at;
        if (fb_at > last_end)   last_end = fb_at;
        last_end = last_end + PULSE;
        while (!fin) begin
            @(negedge clk);
            if (prev_done) begin
                r.ctr_after = ctr;
                after_seen  = 1'b1;
            end
            case (count_instr)
                2'b01:   r.ups++;
                2'b10:   r.downs++;
                2'b11:   r.illegal++;
                default: ;
            endcase
            if (slip) begin
                r.slips++;
                r.lock_slip = int'(lock);
            end
            if (timeout) r.timeouts++;
            if (done) begin
                r.dones++;
                r.ctr_done   = ctr;
                r.clear_done = int'(clear);
                r.lock_done  = int'(lock);
            end
            prev_done = done;
            ref_clk   = pulse_at(c, ref_at) | pulse_at(c, ref2_at);
            fb_clk    = pulse_at(c, fb_at);
            c++;
            if ((after_seen && c >= last_end) || c >= BUDGET) fin = 1'b1;
        end
        ref_clk = 1'b0;
        fb_clk  = 1'b0;
    endtask

    initial begin
        res_t r;
        int   dones_post;
        int   instr_post;
        bit   seen;

        rst = 1'b1; ref_clk = 1'b0; fb_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("rst instr",   int'(count_instr), 0);
        check("rst done",    int'(done), 0);
        check("rst clear",   int'(clear), 0);
        check("rst slip",    int'(slip), 0);
        check("rst timeout", int'(timeout), 0);
        check("rst lock",    int'(lock), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle instr", int'(count_instr), 0);
        check("idle done",  int'(done), 0);

        // ref leads 10, fb leads 7, then 16 zero-length windows reaching lock
        vecs.push_back(mk(0, -1, 10, 10, 0, 10, 0, 0, 0));
        vecs.push_back(mk(7, -1, 0, 0, 7, -7, 0, 0, 0));
        for (int i = 0; i < 16; i++) vecs.push_back(mk(0, -1, 0, 0, 0, 0, 0, 0, (i == 15) ? 1 : 0));
        // Length 5 is one past tolerance: lock drops; 15 zero + one length-4 window relocks
        vecs.push_back(mk(0, -1, 5, 5, 0, 5, 0, 0, 0));
        for (int i = 0; i < 15; i++) vecs.push_back(mk(0, -1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, -1, 4, 4, 0, 4, 0, 0, 1));
        // Second ref edge slips, fb never arrives: forced close after MAX_WIN up cycles
        vecs.push_back(mk(0, 6, -1, MAX_WIN, 0, MAX_WIN, 1, 1, 0));

        foreach (vecs[i]) begin
            run_window(vecs[i].ref_at, vecs[i].ref2_at, vecs[i].fb_at, r);
            check($sformatf("v%0d dones", i),     r.dones, 1);
            check($sformatf("v%0d ups", i),       r.ups, vecs[i].ups);
            check($sformatf("v%0d downs", i),     r.downs, vecs[i].downs);
            check($sformatf("v%0d illegal", i),   r.illegal, 0);
            check($sformatf("v%0d ctr_done", i),  r.ctr_done, vecs[i].ctr);
            check($sformatf("v%0d clear", i),     r.clear_done, 1);
            check($sformatf("v%0d ctr_after", i), r.ctr_after, 0);
            check($sformatf("v%0d slips", i),     r.slips, vecs[i].slips);
            check($sformatf("v%0d timeouts", i),  r.timeouts, vecs[i].timeouts);
            check($sformatf("v%0d lock", i),      r.lock_done, vecs[i].lock);
            if (vecs[i].slips > 0) check($sformatf("v%0d lock_at_slip", i), r.lock_slip, 0);
        end

        // Relock, then reset in the middle of a ref-led window
        for (int i = 0; i < 16; i++) run_window(0, -1, 0, r);
        check("relock", int'(lock), 1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (count_instr == 2'b01) seen = 1'b1;
            ref_clk = (c < PULSE);
        end
        ref_clk = 1'b0;
        check("window opened", int'(seen), 1);
        repeat (2) @(negedge clk);
        check("mid window instr", int'(count_instr), 1);
        rst = 1'b1;
        #1;
        check("async rst instr", int'(count_instr), 0);
        check("async rst lock",  int'(lock), 0);
        @(negedge clk);
        rst = 1'b0;
        dones_post = 0;
        instr_post = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) dones_post++;
            if (count_instr != 2'b00) instr_post++;
        end
        check("post rst dones", dones_post, 0);
        check("post rst instr", instr_post, 0);
        check("post rst ctr",   ctr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
